// File: rtl/csr_access_if.sv
// Request/response and regfile-side signals of the CSR access unit.
// slave = the unit itself, master = execute/writeback/regfile side.
interface csr_access_if #(
  parameter int REG_WIDTH = 64
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [2:0]           req_funct3_i;
  logic [11:0]          req_csr_addr_i;
  logic [4:0]           req_rs1_idx_i;
  logic [REG_WIDTH-1:0] req_rs1_data_i;
  logic [4:0]           req_rd_idx_i;
  logic [1:0]           priv_mode_i;
  logic [11:0]          csr_addr_o;
  logic                 csr_write_ena_o;
  logic [REG_WIDTH-1:0] csr_data_o;
  logic [REG_WIDTH-1:0] csr_data_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [4:0]           rsp_rd_idx_o;
  logic [REG_WIDTH-1:0] rsp_rd_data_o;
  logic                 rsp_rd_write_o;
  logic                 rsp_illegal_o;

  modport slave (
    input  req_valid_i, req_funct3_i, req_csr_addr_i, req_rs1_idx_i,
           req_rs1_data_i, req_rd_idx_i, priv_mode_i, csr_data_i, rsp_ready_i,
    output req_ready_o, csr_addr_o, csr_write_ena_o, csr_data_o,
           rsp_valid_o, rsp_rd_idx_o, rsp_rd_data_o, rsp_rd_write_o, rsp_illegal_o
  );

  modport master (
    output req_valid_i, req_funct3_i, req_csr_addr_i, req_rs1_idx_i,
           req_rs1_data_i, req_rd_idx_i, priv_mode_i, csr_data_i, rsp_ready_i,
    input  req_ready_o, csr_addr_o, csr_write_ena_o, csr_data_o,
           rsp_valid_o, rsp_rd_idx_o, rsp_rd_data_o, rsp_rd_write_o, rsp_illegal_o
  );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write sequencer between execute stage and CSR regfile.
// Optional macro CSR_PRIV_CHECK_EN adds the addr[9:8] vs. privilege check.
//
// state | meaning
// IDLE  | ready for a request, nothing in flight
// READ  | regfile addressed, old value captured, legality decided
// WRITE | single write strobe with the modified value
// RESP  | response held until writeback accepts it
module csr_access_unit #(
  parameter int REG_WIDTH = 64
) (
  input logic         clk_sys_i,
  input logic         rst_sys_i,
  csr_access_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t               state_q, state_d;
  logic [2:0]           funct3_q;
  logic [11:0]          addr_q;
  logic [4:0]           rs1_idx_q;
  logic [REG_WIDTH-1:0] rs1_data_q;
  logic [4:0]           rd_idx_q;
  logic [REG_WIDTH-1:0] old_q;
  logic                 illegal_q;

  logic [REG_WIDTH-1:0] src_c;
  logic [REG_WIDTH-1:0] wdata_c;
  logic                 wr_intent_c;
  logic                 priv_bad_c;
  logic                 illegal_c;

  // Immediate forms carry uimm in the rs1 index field.
  assign src_c       = funct3_q[2] ? {{(REG_WIDTH-5){1'b0}}, rs1_idx_q} : rs1_data_q;
  assign wr_intent_c = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);

`ifdef CSR_PRIV_CHECK_EN
  assign priv_bad_c = (addr_q[9:8] > bus.priv_mode_i);
`else
  logic unused_priv;
  assign unused_priv = ^bus.priv_mode_i;
  assign priv_bad_c  = 1'b0;
`endif

  assign illegal_c = (funct3_q[1:0] == 2'b00)
                   || (wr_intent_c && (addr_q[11:10] == 2'b11))
                   || priv_bad_c;

  always_comb begin
    wdata_c = src_c;
    case (funct3_q[1:0])
      2'b10:   wdata_c = old_q | src_c;
      2'b11:   wdata_c = old_q & ~src_c;
      default: wdata_c = src_c;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state_q    <= IDLE;
      funct3_q   <= '0;
      addr_q     <= '0;
      rs1_idx_q  <= '0;
      rs1_data_q <= '0;
      rd_idx_q   <= '0;
      old_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req_valid_i) begin
        funct3_q   <= bus.req_funct3_i;
        addr_q     <= bus.req_csr_addr_i;
        rs1_idx_q  <= bus.req_rs1_idx_i;
        rs1_data_q <= bus.req_rs1_data_i;
        rd_idx_q   <= bus.req_rd_idx_i;
      end
      if (state_q == READ) begin
        old_q     <= bus.csr_data_i;
        illegal_q <= illegal_c;
      end
    end
  end

  // Outputs decode from state only, so reset drops the write strobe at once.
  always_comb begin
    state_d             = state_q;
    bus.req_ready_o     = 1'b0;
    bus.csr_addr_o      = '0;
    bus.csr_write_ena_o = 1'b0;
    bus.csr_data_o      = '0;
    bus.rsp_valid_o     = 1'b0;
    bus.rsp_rd_idx_o    = '0;
    bus.rsp_rd_data_o   = '0;
    bus.rsp_rd_write_o  = 1'b0;
    bus.rsp_illegal_o   = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) state_d = READ;
      end
      READ: begin
        bus.csr_addr_o = addr_q;
        if (illegal_c)        state_d = RESP;
        else if (wr_intent_c) state_d = WRITE;
        else                  state_d = RESP;
      end
      WRITE: begin
        bus.csr_addr_o      = addr_q;
        bus.csr_write_ena_o = 1'b1;
        bus.csr_data_o      = wdata_c;
        state_d             = RESP;
      end
      RESP: begin
        bus.rsp_valid_o    = 1'b1;
        bus.rsp_rd_idx_o   = rd_idx_q;
        bus.rsp_rd_data_o  = illegal_q ? '0 : old_q;
        bus.rsp_rd_write_o = (rd_idx_q != 5'd0) && !illegal_q;
        bus.rsp_illegal_o  = illegal_q;
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Scoreboard bench for csr_access_unit: stimulus pushes expected writes and
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_csr_access_unit;
  localparam int W = 64;
`ifdef CSR_PRIV_CHECK_EN
  localparam bit PRIV_EN = 1'b1;
`else
  localparam bit PRIV_EN = 1'b0;
`endif

  logic clk_sys_i = 1'b0;
  logic rst_sys_i = 1'b1;
  always #5 clk_sys_i = ~clk_sys_i;

  csr_access_if #(.REG_WIDTH(W)) bus ();
  csr_access_unit #(.REG_WIDTH(W)) dut (
    .clk_sys_i(clk_sys_i),
    .rst_sys_i(rst_sys_i),
    .bus      (bus)
  );

  // Regfile model: returns the staged value only when the right CSR is addressed.
  logic [W-1:0] rf_val  = '0;
  logic [11:0]  rf_addr = '0;
  assign bus.csr_data_i = (bus.csr_addr_o == rf_addr) ? rf_val : 64'hBAD0_BAD0_BAD0_BAD0;

  typedef struct {
    logic [4:0]   rd_idx;
    logic [W-1:0] rd_data;
    logic         rd_write;
    logic         illegal;
    int           cyc;
  } rsp_t;
  typedef struct {
    logic [11:0]  addr;
    logic [W-1:0] data;
    int           cyc;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic seen_valid = 1'b0;
  rsp_t mon_r;
  wr_t  mon_w;

  always @(posedge clk_sys_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_sys_i) begin
    if (!rst_sys_i) begin
      if (bus.csr_write_ena_o) begin
        if (wr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got addr %h data %h expected no strobe", bus.csr_addr_o, bus.csr_data_o);
        end else begin
          mon_w = wr_q.pop_front();
          check("wr_addr", bus.csr_addr_o, mon_w.addr);
          check("wr_data", bus.csr_data_o, mon_w.data);
          check("wr_cycle", cyc, mon_w.cyc);
        end
      end
      if (bus.rsp_valid_o) begin
        if (rsp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp: got rd_data %h expected no response", bus.rsp_rd_data_o);
        end else begin
          if (!seen_valid) begin
            check("rsp_latency", cyc, rsp_q[0].cyc);
            seen_valid = 1'b1;
          end
          if (bus.rsp_ready_i) begin
            mon_r = rsp_q.pop_front();
            check("rsp_rd_idx",   bus.rsp_rd_idx_o,   mon_r.rd_idx);
            check("rsp_rd_data",  bus.rsp_rd_data_o,  mon_r.rd_data);
            check("rsp_rd_write", bus.rsp_rd_write_o, mon_r.rd_write);
            check("rsp_illegal",  bus.rsp_illegal_o,  mon_r.illegal);
            seen_valid = 1'b0;
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the READ cycle.
  task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                       input logic [W-1:0] rs1d, input logic [4:0] rd, input logic [W-1:0] old,
                       input logic do_wr, input logic [W-1:0] wdata, input logic ill,
                       input logic track);
    int n;
    rsp_t r;
    wr_t  w;
    n = 0;
    while (!bus.req_ready_o && n < 50) begin
      @(posedge clk_sys_i); #1; n++;
    end
    if (!bus.req_ready_o) begin
      tests++; fails++;
      $display("FAIL ready_timeout: got req_ready 0 expected 1");
      return;
    end
    rf_val             = old;
    rf_addr            = addr;
    bus.req_funct3_i   = f3;
    bus.req_csr_addr_i = addr;
    bus.req_rs1_idx_i  = rs1;
    bus.req_rs1_data_i = rs1d;
    bus.req_rd_idx_i   = rd;
    bus.req_valid_i    = 1'b1;
    @(posedge clk_sys_i); #1;
    bus.req_valid_i = 1'b0;
    if (track) begin
      if (do_wr) begin
        w.addr = addr; w.data = wdata; w.cyc = cyc + 1;
        wr_q.push_back(w);
      end
      r.rd_idx   = rd;
      r.rd_data  = ill ? '0 : old;
      r.rd_write = (rd != 5'd0) && !ill;
      r.illegal  = ill;
      r.cyc      = cyc + (do_wr ? 2 : 1);
      rsp_q.push_back(r);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < 100) begin
      @(posedge clk_sys_i); #1; n++;
    end
    check("drain_rsp_q", rsp_q.size(), 0);
  endtask

  initial begin
    bus.req_valid_i    = 1'b0;
    bus.req_funct3_i   = '0;
    bus.req_csr_addr_i = '0;
    bus.req_rs1_idx_i  = '0;
    bus.req_rs1_data_i = '0;
    bus.req_rd_idx_i   = '0;
    bus.priv_mode_i    = 2'b11;
    bus.rsp_ready_i    = 1'b1;

    #3;
    check("rst_req_ready", bus.req_ready_o, 1);
    check("rst_rsp_valid", bus.rsp_valid_o, 0);
    check("rst_write_ena", bus.csr_write_ena_o, 0);
    check("rst_csr_addr",  bus.csr_addr_o, 0);
    @(posedge clk_sys_i); #2 rst_sys_i = 1'b0;
    @(posedge clk_sys_i); #1;

    //    f3      addr    rs1    rs1 data               rd     old                    wr    wdata                  ill
    issue(3'b001, 12'h340, 5'd5, 64'hDEAD,              5'd6,  64'h1234,              1'b1, 64'hDEAD,              1'b0, 1'b1);
    issue(3'b010, 12'h300, 5'd0, 64'hFFFF,              5'd7,  64'h8,                 1'b0, 64'h0,                 1'b0, 1'b1);
    issue(3'b111, 12'h340, 5'd3, 64'hFFFF_FFFF,         5'd8,  64'hF,                 1'b1, 64'hC,                 1'b0, 1'b1);
    issue(3'b001, 12'hF14, 5'd1, 64'h5,                 5'd9,  64'h77,                1'b0, 64'h0,                 1'b1, 1'b1);
    issue(3'b010, 12'hF14, 5'd0, 64'h5,                 5'd10, 64'h42,                1'b0, 64'h0,                 1'b0, 1'b1);
    issue(3'b010, 12'h305, 5'd3, 64'hF0,                5'd0,  64'h0F,                1'b1, 64'hFF,                1'b0, 1'b1);
    issue(3'b011, 12'h340, 5'd2, 64'hFF00,              5'd1,  64'hFFFF,              1'b1, 64'h00FF,              1'b0, 1'b1);
    issue(3'b000, 12'h340, 5'd1, 64'h1,                 5'd2,  64'h5,                 1'b0, 64'h0,                 1'b1, 1'b1);
    issue(3'b100, 12'h340, 5'd1, 64'h1,                 5'd2,  64'h6,                 1'b0, 64'h0,                 1'b1, 1'b1);
    issue(3'b101, 12'h340, 5'd0, 64'hFFFF,              5'd11, 64'hAB,                1'b1, 64'h0,                 1'b0, 1'b1);
    issue(3'b110, 12'h340, 5'd0, 64'hFFFF,              5'd12, 64'hCD,                1'b0, 64'h0,                 1'b0, 1'b1);
    issue(3'b010, 12'h340, 5'd1, 64'h8000_0000_0000_0000, 5'd13, 64'h1,               1'b1, 64'h8000_0000_0000_0001, 1'b0, 1'b1);
    issue(3'b110, 12'h340, 5'd31, 64'h0,                5'd14, 64'h100,               1'b1, 64'h11F,               1'b0, 1'b1);
    issue(3'b011, 12'hC00, 5'd0, 64'hFFFF,              5'd15, 64'hFFFF_0000_0000_FFFF, 1'b0, 64'h0,              1'b0, 1'b1);
    drain();

    // Privilege: only illegal when the check is compiled in.
    bus.priv_mode_i = 2'b00;
    issue(3'b010, 12'h300, 5'd0, 64'h0, 5'd4, 64'h11, 1'b0, 64'h0, PRIV_EN, 1'b1);
    drain();
    bus.priv_mode_i = 2'b01;
    issue(3'b010, 12'h100, 5'd0, 64'h0, 5'd4, 64'h22, 1'b0, 64'h0, 1'b0, 1'b1);
    issue(3'b001, 12'h340, 5'd9, 64'h9, 5'd4, 64'h33, !PRIV_EN, 64'h9, PRIV_EN, 1'b1);
    drain();
    bus.priv_mode_i = 2'b11;
    issue(3'b010, 12'h300, 5'd0, 64'h0, 5'd4, 64'h44, 1'b0, 64'h0, 1'b0, 1'b1);
    drain();

    // Back-pressure: response held stable while rsp_ready_i is low.
    bus.rsp_ready_i = 1'b0;
    issue(3'b001, 12'h341, 5'd4, 64'h55, 5'd3, 64'h99, 1'b1, 64'h55, 1'b0, 1'b1);
    begin
      int n;
      n = 0;
      while (!bus.rsp_valid_o && n < 20) begin
        @(posedge clk_sys_i); #1; n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_valid", bus.rsp_valid_o, 1);
      check("stall_rsp_data",  bus.rsp_rd_data_o, 64'h99);
      check("stall_req_ready", bus.req_ready_o, 0);
      @(posedge clk_sys_i); #1;
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk_sys_i); #1;
    check("stall_idle_resume", bus.req_ready_o, 1);
    drain();

    // Reset during WRITE: strobe drops at once, no response follows.
    issue(3'b001, 12'h340, 5'd1, 64'h1, 5'd2, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0);
    @(posedge clk_sys_i); #1;
    check("pre_reset_strobe", bus.csr_write_ena_o, 1);
    #1 rst_sys_i = 1'b1;
    #1;
    check("reset_strobe_drop", bus.csr_write_ena_o, 0);
    @(posedge clk_sys_i); #3 rst_sys_i = 1'b0;
    repeat (4) @(posedge clk_sys_i);
    #1;
    check("post_reset_ready", bus.req_ready_o, 1);
    check("post_reset_no_rsp", bus.rsp_valid_o, 0);

    issue(3'b001, 12'h340, 5'd7, 64'h7777, 5'd5, 64'h6666, 1'b1, 64'h7777, 1'b0, 1'b1);
    drain();
    repeat (2) @(posedge clk_sys_i);
    #1;
    check("wr_q_empty", wr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule
